// File: rtl/k052109_pkg.sv
// Shared types and constants for the K052109 tile-layer VRAM scheduler.
package k052109_pkg;

  localparam logic [1:0] LYR_FIX = 2'd0;
  localparam logic [1:0] LYR_A   = 2'd1;
  localparam logic [1:0] LYR_B   = 2'd2;
  localparam logic [1:0] LYR_SCR = 2'd3;

  typedef enum logic [1:0] {
    SK_IDLE,
    SK_FETCH,
    SK_CPURD,
    SK_CPUWR
  } slot_kind_e;

  localparam int PH_ADDR = 0;
  localparam int PH_STB  = 1;
  localparam int PH_CAP  = 2;
  localparam int PH_DONE = 3;

  // Active-low per-lane enable pattern for ROE/RWE[1:0].
  function automatic logic [1:0] lane_mask_n(input logic lane);
    return lane ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/k052109_slot_timer.sv
// Phase/slot counters for the VRAM schedule; line_start realigns to slot 0 / phase 0.
module k052109_slot_timer
  import k052109_pkg::*;
#(
  parameter int SLOTS    = 8,
  parameter int SLOT_LEN = 4,
  localparam int SW      = $clog2(SLOTS),
  localparam int PW      = $clog2(SLOT_LEN)
) (
  input  logic          i_clk,
  input  logic          i_srst,
  input  logic          i_line_start,
  output logic [SW-1:0] o_slot,
  output logic [PW-1:0] o_phase,
  output logic          o_slot_start
);

  logic [SW-1:0] r_slot;
  logic [PW-1:0] r_phase;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_line_start) begin
      r_slot  <= '0;
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
      if (r_phase == PW'(SLOT_LEN - 1))
        r_slot <= r_slot + SW'(1);
    end
  end

  assign o_slot       = r_slot;
  assign o_phase      = r_phase;
  assign o_slot_start = (r_phase == PW'(PH_ADDR));

endmodule

// File: rtl/k052109_vram_sched.sv
// VRAM bus scheduler: fixed fetch slots on even slots, opportunistic CPU access otherwise.
module k052109_vram_sched
  import k052109_pkg::*;
#(
  parameter int SLOTS    = 8,
  parameter int SLOT_LEN = 4
) (
  input  logic        i_m24,
  input  logic        i_res,
  input  logic        i_line_start,
  input  logic        i_fetch_en,
  input  logic [12:0] i_fa_fix,
  input  logic [12:0] i_fa_a,
  input  logic [12:0] i_fa_b,
  input  logic [12:0] i_fa_scr,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [13:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_fetch_valid,
  output logic [1:0]  o_fetch_layer,
  output logic [15:0] o_fetch_data,
  output logic [12:0] o_ra,
  output logic [1:0]  o_rcs,
  output logic [2:0]  o_roe,
  output logic [2:0]  o_rwe,
  input  logic [15:0] i_vd_in,
  output logic [15:0] o_vd_out,
  output logic        o_vd_oe
);

  localparam int SW = $clog2(SLOTS);
  localparam int PW = $clog2(SLOT_LEN);

  logic [SW-1:0] w_slot;
  logic [PW-1:0] w_phase;
  logic          w_slot_start;
  logic [1:0]    w_layer;
  logic [12:0]   w_fa [4];

  k052109_slot_timer #(.SLOTS(SLOTS), .SLOT_LEN(SLOT_LEN)) u_timer (
    .i_clk        (i_m24),
    .i_srst       (i_res),
    .i_line_start (i_line_start),
    .o_slot       (w_slot),
    .o_phase      (w_phase),
    .o_slot_start (w_slot_start)
  );

  assign w_layer = 2'(w_slot >> 1);
  assign w_fa[0] = i_fa_fix;
  assign w_fa[1] = i_fa_a;
  assign w_fa[2] = i_fa_b;
  assign w_fa[3] = i_fa_scr;

  slot_kind_e  r_kind;
  logic [1:0]  r_layer;
  logic        r_lane;
  logic        r_ack, r_valid, r_vd_oe;
  logic [7:0]  r_rdata;
  logic [1:0]  r_fetch_layer, r_rcs;
  logic [15:0] r_fetch_data, r_vd_out;
  logic [12:0] r_ra;
  logic [2:0]  r_roe, r_rwe;

  // Outputs for access phase N are loaded on the edge that ends timer phase N,
  // so the vd_in sample on the PH_DONE edge lands at the end of the strobe window.
  always_ff @(posedge i_m24) begin
    if (i_res) begin
      r_kind        <= SK_IDLE;
      r_layer       <= LYR_FIX;
      r_lane        <= 1'b0;
      r_ack         <= 1'b0;
      r_valid       <= 1'b0;
      r_rdata       <= '0;
      r_fetch_layer <= LYR_FIX;
      r_fetch_data  <= '0;
      r_ra          <= '0;
      r_rcs         <= 2'b11;
      r_roe         <= 3'b111;
      r_rwe         <= 3'b111;
      r_vd_out      <= '0;
      r_vd_oe       <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      if (i_line_start) begin
        r_kind  <= SK_IDLE;
        r_rcs   <= 2'b11;
        r_roe   <= 3'b111;
        r_rwe   <= 3'b111;
        r_vd_oe <= 1'b0;
      end else if (w_slot_start) begin
        r_roe <= 3'b111;
        r_rwe <= 3'b111;
        if (!w_slot[0] && i_fetch_en) begin
          r_kind  <= SK_FETCH;
          r_layer <= w_layer;
          r_ra    <= w_fa[w_layer];
          r_rcs   <= 2'b00;
          r_vd_oe <= 1'b0;
        end else if (i_cpu_req) begin
          r_kind   <= i_cpu_we ? SK_CPUWR : SK_CPURD;
          r_lane   <= i_cpu_addr[13];
          r_ra     <= i_cpu_addr[12:0];
          // Chip selects are ordered opposite to the ROE/RWE lane bits.
          r_rcs    <= ~lane_mask_n(i_cpu_addr[13]);
          r_vd_out <= {i_cpu_wdata, i_cpu_wdata};
          r_vd_oe  <= i_cpu_we;
        end else begin
          r_kind  <= SK_IDLE;
          r_rcs   <= 2'b11;
          r_vd_oe <= 1'b0;
        end
      end else if (w_phase == PW'(PH_STB) || w_phase == PW'(PH_CAP)) begin
        case (r_kind)
          SK_FETCH: r_roe <= 3'b100;
          SK_CPURD: r_roe <= {1'b1, lane_mask_n(r_lane)};
          SK_CPUWR: r_rwe <= {1'b1, lane_mask_n(r_lane)};
          default:  ;
        endcase
      end else begin
        r_kind  <= SK_IDLE;
        r_rcs   <= 2'b11;
        r_roe   <= 3'b111;
        r_rwe   <= 3'b111;
        r_vd_oe <= 1'b0;
        if (w_phase == PW'(PH_DONE)) begin
          case (r_kind)
            SK_FETCH: begin
              r_fetch_data  <= i_vd_in;
              r_fetch_layer <= r_layer;
              r_valid       <= 1'b1;
            end
            SK_CPURD: begin
              r_rdata <= r_lane ? i_vd_in[15:8] : i_vd_in[7:0];
              r_ack   <= 1'b1;
            end
            SK_CPUWR: r_ack <= 1'b1;
            default:  ;
          endcase
        end
      end
    end
  end

  assign o_cpu_ack     = r_ack;
  assign o_cpu_rdata   = r_rdata;
  assign o_fetch_valid = r_valid;
  assign o_fetch_layer = r_fetch_layer;
  assign o_fetch_data  = r_fetch_data;
  assign o_ra          = r_ra;
  assign o_rcs         = r_rcs;
  assign o_roe         = r_roe;
  assign o_rwe         = r_rwe;
  assign o_vd_out      = r_vd_out;
  assign o_vd_oe       = r_vd_oe;

endmodule

// File: tb/tb_k052109_vram_sched.sv
// Directed bench for the K052109 VRAM scheduler: fetch timing, CPU read/write, abort, wrap.
module tb_k052109_vram_sched;

  logic        clk = 1'b0;
  logic        res, line_start, fetch_en;
  logic [12:0] fa_fix, fa_a, fa_b, fa_scr;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        fetch_valid;
  logic [1:0]  fetch_layer;
  logic [15:0] fetch_data;
  logic [12:0] ra;
  logic [1:0]  rcs;
  logic [2:0]  roe, rwe;
  logic [15:0] vd_in, vd_out;
  logic        vd_oe;

  int checks = 0;
  int errors = 0;

  // Bench-side schedule: slot/phase the DUT acted on at the most recent edge.
  int m_slot = 0, m_phase = 0;
  int e_slot = 0, e_phase = 0;
  bit e_ok = 1'b0;

  always #5 clk = ~clk;

  k052109_vram_sched dut (
    .i_m24(clk), .i_res(res), .i_line_start(line_start), .i_fetch_en(fetch_en),
    .i_fa_fix(fa_fix), .i_fa_a(fa_a), .i_fa_b(fa_b), .i_fa_scr(fa_scr),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_fetch_valid(fetch_valid),
    .o_fetch_layer(fetch_layer), .o_fetch_data(fetch_data), .o_ra(ra), .o_rcs(rcs),
    .o_roe(roe), .o_rwe(rwe), .i_vd_in(vd_in), .o_vd_out(vd_out), .o_vd_oe(vd_oe)
  );

  always @(posedge clk) begin
    e_slot  <= m_slot;
    e_phase <= m_phase;
    e_ok    <= !res && !line_start;
    if (res || line_start) begin
      m_slot  <= 0;
      m_phase <= 0;
    end else if (m_phase == 3) begin
      m_phase <= 0;
      m_slot  <= (m_slot + 1) % 8;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // Return at the negedge where outputs for access phase k of slot s are visible.
  task automatic wait_out(input int s, input int k);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (e_ok && e_slot == s && e_phase == k) return;
    end
    checks++; errors++;
    $display("FAIL wait_out slot=%0d ph=%0d: timeout after 200 cycles, required slot reached", s, k);
  endtask

  task automatic test_reset();
    res = 1'b1; line_start = 1'b0; fetch_en = 1'b1;
    fa_fix = 13'h1ABC; fa_a = 13'h0123; fa_b = 13'h0B0B; fa_scr = 13'h05C5;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vd_in = 16'h1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ra, rcs, roe, rwe, vd_oe, cpu_ack, fetch_valid, fetch_layer, fetch_data, cpu_rdata} !==
        {13'h0, 2'b11, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_vals: ra=%h rcs=%b roe=%b rwe=%b oe=%b ack=%b v=%b lyr=%0d fd=%h rd=%h required 0/11/111/111/0/0/0/0/0/0",
               ra, rcs, roe, rwe, vd_oe, cpu_ack, fetch_valid, fetch_layer, fetch_data, cpu_rdata);
    end
    res = 1'b0;
    wait_out(0, 0);
    checks++;
    if (ra !== 13'h1ABC || rcs !== 2'b00 || roe !== 3'b111) begin
      errors++;
      $display("FAIL first_fetch_ph0: ra=%h rcs=%b roe=%b required 1abc/00/111", ra, rcs, roe);
    end
    wait_out(0, 1);
    checks++;
    if (roe !== 3'b100 || vd_oe !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch_ph1: roe=%b vd_oe=%b required 100/0", roe, vd_oe);
    end
    wait_out(0, 3);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_layer !== 2'd0 || fetch_data !== 16'h1111 || roe !== 3'b111) begin
      errors++;
      $display("FAIL first_fetch_ph3: v=%b lyr=%0d data=%h roe=%b required 1/0/1111/111",
               fetch_valid, fetch_layer, fetch_data, roe);
    end
  endtask

  task automatic test_fetch_a();
    vd_in = 16'hBEEF;
    wait_out(2, 0);
    checks++;
    if (ra !== 13'h0123 || rcs !== 2'b00) begin
      errors++;
      $display("FAIL fetch_a_addr: ra=%h rcs=%b required 0123/00", ra, rcs);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_valid !== (i == 3)) begin
        errors++;
        $display("FAIL fetch_a_latency: cycle %0d valid=%b required %b", i, fetch_valid, i == 3);
      end
    end
    checks++;
    if (fetch_layer !== 2'd1 || fetch_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_a_data: lyr=%0d data=%h required 1/beef", fetch_layer, fetch_data);
    end
    wait_out(3, 0);
    checks++;
    if (rcs !== 2'b11 || ra !== 13'h0123) begin
      errors++;
      $display("FAIL odd_idle: rcs=%b ra=%h required 11/0123", rcs, ra);
    end
    wait_out(3, 3);
    checks++;
    if (fetch_valid !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL odd_idle_done: valid=%b ack=%b required 0/0", fetch_valid, cpu_ack);
    end
  endtask

  task automatic test_cpu_write();
    int acks;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2456; cpu_wdata = 8'h5A;
    wait_out(4, 3);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_layer !== 2'd2 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL even_keeps_fetch: valid=%b lyr=%0d ack=%b required 1/2/0", fetch_valid, fetch_layer, cpu_ack);
    end
    wait_out(5, 0);
    acks = int'(cpu_ack);
    checks++;
    if (ra !== 13'h0456 || rcs !== 2'b10 || rwe !== 3'b111 || vd_oe !== 1'b1 || vd_out[15:8] !== 8'h5A) begin
      errors++;
      $display("FAIL wr_ph0: ra=%h rcs=%b rwe=%b oe=%b vd_out=%h required 0456/10/111/1/5a..", ra, rcs, rwe, vd_oe, vd_out);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      acks += int'(cpu_ack);
      checks++;
      if (rwe !== 3'b101 || roe !== 3'b111 || vd_oe !== 1'b1) begin
        errors++;
        $display("FAIL wr_strobe ph%0d: rwe=%b roe=%b oe=%b required 101/111/1", k, rwe, roe, vd_oe);
      end
    end
    @(negedge clk);
    acks += int'(cpu_ack);
    checks++;
    if (acks != 1 || cpu_ack !== 1'b1 || rwe !== 3'b111 || vd_oe !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: acks=%0d ack=%b rwe=%b oe=%b required 1/1/111/0", acks, cpu_ack, rwe, vd_oe);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_read_blank();
    int vcnt = 0, acnt = 0;
    fetch_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; vd_in = 16'h12C3;
    wait_out(6, 0);
    checks++;
    if (ra !== 13'h0010 || rcs !== 2'b01 || vd_oe !== 1'b0) begin
      errors++;
      $display("FAIL rd_ph0: ra=%h rcs=%b oe=%b required 0010/01/0", ra, rcs, vd_oe);
    end
    wait_out(6, 1);
    checks++;
    if (roe !== 3'b110 || rwe !== 3'b111) begin
      errors++;
      $display("FAIL rd_ph1: roe=%b rwe=%b required 110/111", roe, rwe);
    end
    wait_out(6, 3);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hC3 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: ack=%b rdata=%h valid=%b required 1/c3/0", cpu_ack, cpu_rdata, fetch_valid);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      vcnt += int'(fetch_valid);
      acnt += int'(cpu_ack);
    end
    checks++;
    if (vcnt != 0 || acnt != 0 || cpu_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL blank_frame: valids=%0d acks=%0d rdata=%h required 0/0/c3", vcnt, acnt, cpu_rdata);
    end
  endtask

  task automatic test_line_start_abort();
    int acks = 0;
    fetch_en = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0077; cpu_wdata = 8'hA5;
    wait_out(1, 0);
    checks++;
    if (ra !== 13'h0077 || rcs !== 2'b01 || vd_oe !== 1'b1 || vd_out !== 16'hA5A5) begin
      errors++;
      $display("FAIL ab_ph0: ra=%h rcs=%b oe=%b vd_out=%h required 0077/01/1/a5a5", ra, rcs, vd_oe, vd_out);
    end
    wait_out(1, 1);
    checks++;
    if (rwe !== 3'b110) begin
      errors++;
      $display("FAIL ab_ph1: rwe=%b required 110", rwe);
    end
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    acks += int'(cpu_ack);
    checks++;
    if (rwe !== 3'b111 || vd_oe !== 1'b0 || cpu_ack !== 1'b0 || rcs !== 2'b11) begin
      errors++;
      $display("FAIL abort: rwe=%b oe=%b ack=%b rcs=%b required 111/0/0/11", rwe, vd_oe, cpu_ack, rcs);
    end
    @(negedge clk);
    acks += int'(cpu_ack);
    checks++;
    if (ra !== 13'h1ABC || rcs !== 2'b00) begin
      errors++;
      $display("FAIL realign_slot0: ra=%h rcs=%b required 1abc/00", ra, rcs);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      acks += int'(cpu_ack);
    end
    checks++;
    if (acks != 1 || cpu_ack !== 1'b1 || rwe !== 3'b111) begin
      errors++;
      $display("FAIL retry_write: acks=%0d ack=%b rwe=%b required 1/1/111", acks, cpu_ack, rwe);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_sweep();
    int nv = 0;
    int bad_inv = 0;
    logic [1:0] lyrs [8];
    wait_out(7, 3);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((vd_oe && roe !== 3'b111) || rwe[1:0] === 2'b00) bad_inv++;
      if (fetch_valid) begin
        if (nv < 8) lyrs[nv] = fetch_layer;
        nv++;
      end
      if (cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(1, 0) == 1) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(1, 0));
        cpu_addr  = 14'($urandom);
        cpu_wdata = 8'($urandom);
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (bad_inv != 0) begin
      errors++;
      $display("FAIL sweep_invariants: violations=%0d required 0", bad_inv);
    end
    checks++;
    if (nv != 8) begin
      errors++;
      $display("FAIL sweep_fetch_count: got %0d required 8", nv);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (lyrs[k] !== 2'(k % 4)) begin
          errors++;
          $display("FAIL sweep_layer[%0d]: got %0d required %0d", k, lyrs[k], k % 4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_a();
    test_cpu_write();
    test_cpu_read_blank();
    test_line_start_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
